// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the single-issue core.
// Outputs decode combinationally from the state register; unknown opcodes and stuck memory waits trap.
module riscv_ctrl_fsm #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  output logic             ir_we,
  input  logic             dec_valid,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_rf_wen,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             dmem_rvalid,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    F_REQ  = 3'd0,
    F_WAIT = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    M_REQ  = 3'd4,
    M_WAIT = 3'd5,
    WB     = 3'd6,
    TRAP   = 3'd7
  } state_t;

  // The current cycle is the (wait_cnt+1)-th counted cycle, so the wait that
  // reaches 2^TIMEOUT_W-1 counted cycles without an exit is the last one allowed.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(2**TIMEOUT_W - 2);

  state_t               state, state_nx;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [CNT_W-1:0]     ret_cnt;
  logic                 counting;
  logic                 timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= F_REQ;
      wait_cnt <= '0;
      ret_cnt  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state == WB) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    counting    = (state == F_REQ && run) || (state == F_WAIT) ||
                  (state == M_REQ) || (state == M_WAIT);
    timeout     = counting && (wait_cnt == TO_LAST);

    case (state)
      F_REQ: begin
        if (run && imem_ready) state_nx = F_WAIT;
        else if (timeout)      state_nx = TRAP;
      end
      F_WAIT: begin
        if (imem_rvalid)  state_nx = DECODE;
        else if (timeout) state_nx = TRAP;
      end
      DECODE: state_nx = dec_valid ? EXEC : TRAP;
      EXEC:   state_nx = (dec_is_load || dec_is_store) ? M_REQ : WB;
      M_REQ: begin
        if (dmem_ready)   state_nx = dec_is_store ? WB : M_WAIT;
        else if (timeout) state_nx = TRAP;
      end
      M_WAIT: begin
        if (dmem_rvalid)  state_nx = WB;
        else if (timeout) state_nx = TRAP;
      end
      WB:      state_nx = F_REQ;
      default: state_nx = TRAP;
    endcase

    if (state_nx != state) wait_cnt_nx = '0;
    else if (counting)     wait_cnt_nx = wait_cnt + 1'b1;
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    trap     = 1'b0;
    state_o  = 3'd0;
    retired  = '0;
    if (!rst) begin
      state_o = state;
      retired = ret_cnt;
      case (state)
        F_REQ:  imem_req = run;
        F_WAIT: ir_we    = imem_rvalid;
        M_REQ: begin
          dmem_req = 1'b1;
          dmem_we  = dec_is_store;
        end
        WB: begin
          rf_we = dec_rf_wen;
          pc_we = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed vector bench for riscv_ctrl_fsm with CNT_W=3, TIMEOUT_W=4.
module tb_riscv_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic       dec_valid = 1'b0, dec_is_load = 1'b0, dec_is_store = 1'b0, dec_rf_wen = 1'b0;
  logic       dmem_ready = 1'b0, dmem_rvalid = 1'b0;
  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap;
  logic [2:0] state_o;
  logic [2:0] retired;

  riscv_ctrl_fsm #(.CNT_W(3), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .ir_we(ir_we),
    .dec_valid(dec_valid), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_rf_wen(dec_rf_wen),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .rf_we(rf_we), .pc_we(pc_we), .trap(trap), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  // decoder flags {dec_valid, dec_is_load, dec_is_store, dec_rf_wen}
  localparam logic [3:0] ALU = 4'b1001;
  localparam logic [3:0] SW  = 4'b1010;
  localparam logic [3:0] LW  = 4'b1101;
  localparam logic [3:0] BAD = 4'b0000;

  // expected outputs {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_IREQ = 7'b1000000;
  localparam logic [6:0] O_IRWE = 7'b0100000;
  localparam logic [6:0] O_LDRQ = 7'b0010000;
  localparam logic [6:0] O_STRQ = 7'b0011000;
  localparam logic [6:0] O_WBRF = 7'b0000110;
  localparam logic [6:0] O_WBNR = 7'b0000010;
  localparam logic [6:0] O_TRAP = 7'b0000001;

  typedef struct {
    string      name;
    logic [9:0] in;
    logic [2:0] st;
    logic [6:0] out;
    logic [2:0] ret;
  } vec_t;

  int   nvec  = 0;
  int   nfail = 0;
  vec_t tbl[$];

  function automatic logic [9:0] fi(input logic r, input logic rn, input logic ir, input logic irv,
                                    input logic [3:0] dec, input logic dr, input logic drv);
    return {r, rn, ir, irv, dec, dr, drv};
  endfunction

  function automatic vec_t mk(input string n, input logic [9:0] in, input logic [2:0] st,
                              input logic [6:0] out, input logic [2:0] ret);
    vec_t v;
    v.name = n; v.in = in; v.st = st; v.out = out; v.ret = ret;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge and check outputs before the rising edge.
  task automatic step(input string name, input logic [9:0] in, input logic [2:0] est,
                      input logic [6:0] eout, input logic [2:0] eret);
    logic [6:0] outs;
    @(negedge clk);
    {rst, run, imem_ready, imem_rvalid, dec_valid, dec_is_load, dec_is_store, dec_rf_wen,
     dmem_ready, dmem_rvalid} = in;
    #1;
    outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap};
    nvec++;
    if (state_o !== est || outs !== eout || retired !== eret) begin
      nfail++;
      $display("FAIL %s: got state=%0d outs=%b retired=%0d, want state=%0d outs=%b retired=%0d",
               name, state_o, outs, retired, est, eout, eret);
    end
  endtask

  task automatic alu_instr(input logic [2:0] r);
    step("alu_freq", fi(0,1,1,0,ALU,0,0), 3'd0, O_IREQ, r);
    step("alu_fwait", fi(0,1,0,1,ALU,0,0), 3'd1, O_IRWE, r);
    step("alu_dec", fi(0,1,0,0,ALU,0,0), 3'd2, O_NONE, r);
    step("alu_exec", fi(0,1,0,0,ALU,0,0), 3'd3, O_NONE, r);
    step("alu_wb", fi(0,1,0,0,ALU,0,0), 3'd6, O_WBRF, r);
  endtask

  initial begin
    // reset with every input active: outputs must still be 0
    tbl.push_back(mk("rst_a", fi(1,1,1,1,ALU,1,1), 3'd0, O_NONE, 3'd0));
    tbl.push_back(mk("rst_b", fi(1,1,1,1,ALU,1,1), 3'd0, O_NONE, 3'd0));
    // ADDI: trace 0,1,2,3,6,0
    tbl.push_back(mk("addi_freq", fi(0,1,1,0,ALU,0,0), 3'd0, O_IREQ, 3'd0));
    tbl.push_back(mk("addi_fwait", fi(0,1,0,1,ALU,0,0), 3'd1, O_IRWE, 3'd0));
    tbl.push_back(mk("addi_dec", fi(0,1,0,0,ALU,0,0), 3'd2, O_NONE, 3'd0));
    tbl.push_back(mk("addi_exec", fi(0,1,0,0,ALU,0,0), 3'd3, O_NONE, 3'd0));
    tbl.push_back(mk("addi_wb", fi(0,1,0,0,ALU,0,0), 3'd6, O_WBRF, 3'd0));
    tbl.push_back(mk("addi_done", fi(0,0,1,1,ALU,0,0), 3'd0, O_NONE, 3'd1));
    // SW: trace 0,1,2,3,4,6
    tbl.push_back(mk("sw_freq", fi(0,1,1,0,SW,0,0), 3'd0, O_IREQ, 3'd1));
    tbl.push_back(mk("sw_fwait", fi(0,1,0,1,SW,0,0), 3'd1, O_IRWE, 3'd1));
    tbl.push_back(mk("sw_dec", fi(0,1,0,0,SW,0,0), 3'd2, O_NONE, 3'd1));
    tbl.push_back(mk("sw_exec", fi(0,1,0,0,SW,0,0), 3'd3, O_NONE, 3'd1));
    tbl.push_back(mk("sw_mreq", fi(0,1,0,0,SW,1,0), 3'd4, O_STRQ, 3'd1));
    tbl.push_back(mk("sw_wb", fi(0,1,0,0,SW,0,0), 3'd6, O_WBNR, 3'd1));
    tbl.push_back(mk("sw_done", fi(0,0,0,0,SW,0,0), 3'd0, O_NONE, 3'd2));
    // LW: dmem_ready after 3 cycles, rvalid two cycles after acceptance
    tbl.push_back(mk("lw_freq", fi(0,1,1,0,LW,0,0), 3'd0, O_IREQ, 3'd2));
    tbl.push_back(mk("lw_fwait", fi(0,1,0,1,LW,0,0), 3'd1, O_IRWE, 3'd2));
    tbl.push_back(mk("lw_dec", fi(0,1,0,0,LW,0,0), 3'd2, O_NONE, 3'd2));
    tbl.push_back(mk("lw_exec", fi(0,1,0,0,LW,0,0), 3'd3, O_NONE, 3'd2));
    tbl.push_back(mk("lw_mreq1", fi(0,1,0,0,LW,0,1), 3'd4, O_LDRQ, 3'd2));
    tbl.push_back(mk("lw_mreq2", fi(0,1,0,0,LW,0,0), 3'd4, O_LDRQ, 3'd2));
    tbl.push_back(mk("lw_mreq3", fi(0,1,0,0,LW,0,0), 3'd4, O_LDRQ, 3'd2));
    tbl.push_back(mk("lw_mreq4", fi(0,1,0,0,LW,1,0), 3'd4, O_LDRQ, 3'd2));
    tbl.push_back(mk("lw_mwait1", fi(0,1,0,0,LW,0,0), 3'd5, O_NONE, 3'd2));
    tbl.push_back(mk("lw_mwait2", fi(0,1,0,0,LW,0,1), 3'd5, O_NONE, 3'd2));
    tbl.push_back(mk("lw_wb", fi(0,1,0,0,LW,0,0), 3'd6, O_WBRF, 3'd2));
    tbl.push_back(mk("lw_done", fi(0,0,0,0,LW,0,0), 3'd0, O_NONE, 3'd3));
    // undecodable IR traps right after DECODE
    tbl.push_back(mk("bad_freq", fi(0,1,1,0,BAD,0,0), 3'd0, O_IREQ, 3'd3));
    tbl.push_back(mk("bad_fwait", fi(0,1,0,1,BAD,0,0), 3'd1, O_IRWE, 3'd3));
    tbl.push_back(mk("bad_dec", fi(0,1,0,0,BAD,0,0), 3'd2, O_NONE, 3'd3));
    tbl.push_back(mk("bad_trap", fi(0,1,1,1,ALU,1,1), 3'd7, O_TRAP, 3'd3));

    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].st, tbl[i].out, tbl[i].ret);

    // trap is sticky and masks every strobe while inputs toggle
    for (int i = 0; i < 100; i++)
      step("trap_hold", fi(0,1,i[0],1,ALU,1,~i[0]), 3'd7, O_TRAP, 3'd3);
    step("trap_rst", fi(1,1,1,1,ALU,1,1), 3'd0, O_NONE, 3'd0);

    // run=0 never fetches and never times out, even with imem_ready high
    for (int i = 0; i < 50; i++)
      step("idle", fi(0,0,1,0,ALU,0,0), 3'd0, O_NONE, 3'd0);
    // 15 stuck cycles in F_REQ, then TRAP
    for (int i = 0; i < 15; i++)
      step("to_freq", fi(0,1,0,0,ALU,0,0), 3'd0, O_IREQ, 3'd0);
    step("to_trap", fi(0,1,0,0,ALU,0,0), 3'd7, O_TRAP, 3'd0);
    step("to_rst", fi(1,0,0,0,ALU,0,0), 3'd0, O_NONE, 3'd0);

    // acceptance on the final allowed cycle wins over the timeout
    for (int i = 0; i < 14; i++)
      step("edge_freq", fi(0,1,0,0,ALU,0,0), 3'd0, O_IREQ, 3'd0);
    step("edge_accept", fi(0,1,1,0,ALU,0,0), 3'd0, O_IREQ, 3'd0);
    step("edge_fwait", fi(0,1,0,1,ALU,0,0), 3'd1, O_IRWE, 3'd0);
    step("edge_dec", fi(0,1,0,0,ALU,0,0), 3'd2, O_NONE, 3'd0);
    step("edge_exec", fi(0,1,0,0,ALU,0,0), 3'd3, O_NONE, 3'd0);
    step("edge_wb", fi(0,1,0,0,ALU,0,0), 3'd6, O_WBRF, 3'd0);

    // eight more instructions: 9 retired wraps a 3-bit counter to 1
    for (int i = 1; i < 9; i++) alu_instr(3'(i));

    // reset while a load waits for data
    step("rl_freq", fi(0,1,1,0,LW,0,0), 3'd0, O_IREQ, 3'd1);
    step("rl_fwait", fi(0,1,0,1,LW,0,0), 3'd1, O_IRWE, 3'd1);
    step("rl_dec", fi(0,1,0,0,LW,0,0), 3'd2, O_NONE, 3'd1);
    step("rl_exec", fi(0,1,0,0,LW,0,0), 3'd3, O_NONE, 3'd1);
    step("rl_mreq", fi(0,1,0,0,LW,1,0), 3'd4, O_LDRQ, 3'd1);
    step("rl_mwait", fi(0,1,0,0,LW,0,0), 3'd5, O_NONE, 3'd1);
    step("rl_rst", fi(1,1,1,1,LW,1,1), 3'd0, O_NONE, 3'd0);
    step("rl_after", fi(0,0,0,0,LW,0,0), 3'd0, O_NONE, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
